// File: rtl/ema_sender.sv
// EMA smoother with optional decimation feeding the threshold comparator.
// Keeps one pending result while the comparator is busy and counts overruns.
module ema_sender #(
  parameter int                DATA_W   = 16,
  parameter int                FRAC     = 8,
  parameter int                ADDR_W   = 4,
  parameter logic [ADDR_W-1:0] REG_BASE = 4'h4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              ematop_thcomptop_start,
  output logic [DATA_W-1:0] ematop_thcomptop_data,
  input  logic              thcomptop_ematop_finish,
  output logic              ema_overrun,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data_in,
  output logic [DATA_W-1:0] cfg_data_out,
  output logic [1:0]        dbg_state_o
);

  localparam int ACC_W = DATA_W + FRAC;

  // Comparator handshake: start is a one-cycle request issued only from SEND;
  // finish is honoured only in WAIT and releases the comparator.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic              en_q, en_d;
  logic [2:0]        k_q, k_d;
  logic [7:0]        decim_q, decim_d;
  logic [7:0]        ovr_q, ovr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              seeded_q, seeded_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              pend_q, pend_d;
  logic [DATA_W-1:0] pend_data_q, pend_data_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Register decode
  logic [ADDR_W:0] off;
  logic            in_range;
  logic [1:0]      reg_sel;
  logic            wr_ctrl, wr_decim, wr_ovr;

  assign off      = {1'b0, cfg_addr} - {1'b0, REG_BASE};
  assign in_range = (cfg_addr >= REG_BASE) && (off < (ADDR_W+1)'(4));
  assign reg_sel  = off[1:0];
  assign wr_ctrl  = cfg_we && in_range && (reg_sel == 2'd0);
  assign wr_decim = cfg_we && in_range && (reg_sel == 2'd1);
  assign wr_ovr   = cfg_we && in_range && (reg_sel == 2'd2);

  logic disable_wr;
  assign disable_wr = wr_ctrl && !cfg_data_in[0];

  // EMA datapath: difference is one bit wider so the arithmetic shift floors
  logic                    accept;
  logic [ACC_W-1:0]        sample_ext;
  logic signed [ACC_W:0]   diff;
  logic signed [ACC_W:0]   step;
  logic [ACC_W-1:0]        acc_upd;
  logic                    req;
  logic [DATA_W-1:0]       req_data;

  assign accept     = in_valid && en_q;
  assign sample_ext = {in_data, {FRAC{1'b0}}};
  assign diff       = {sample_ext[ACC_W-1], sample_ext} - {acc_q[ACC_W-1], acc_q};
  assign step       = diff >>> k_q;
  assign acc_upd    = seeded_q ? (acc_q + step[ACC_W-1:0]) : sample_ext;
  assign req_data   = acc_upd[ACC_W-1:FRAC];

  always_comb begin
    acc_d    = acc_q;
    seeded_d = seeded_q;
    cnt_d    = cnt_q;
    req      = 1'b0;
    if (accept) begin
      acc_d    = acc_upd;
      seeded_d = 1'b1;
      if (cnt_q == decim_q) begin
        cnt_d = 8'd0;
        req   = 1'b1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
    if (wr_decim) cnt_d = 8'd0;
    if (disable_wr) begin
      seeded_d = 1'b0;
      cnt_d    = 8'd0;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req || pend_q) state_d = S_SEND;
      S_SEND: state_d = S_WAIT;
      S_WAIT: begin
        if (thcomptop_ematop_finish) state_d = (pend_q || req) ? S_SEND : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    ematop_thcomptop_start = (state_q == S_SEND);
    ematop_thcomptop_data  = data_q;
    dbg_state_o            = state_q;
  end

  // Pending buffer and send-data capture; a fresh request always beats the
  // buffered value, and dropping a buffered value counts as an overrun.
  logic load_send;
  logic ovr_inc;
  assign load_send = (state_d == S_SEND) && (state_q != S_SEND);

  always_comb begin
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    data_d      = data_q;
    ovr_inc     = 1'b0;
    if (load_send) begin
      data_d = req ? req_data : pend_data_q;
      if (req && pend_q) ovr_inc = 1'b1;
      pend_d = 1'b0;
    end else if (req) begin
      if (pend_q) ovr_inc = 1'b1;
      pend_d      = 1'b1;
      pend_data_d = req_data;
    end
    if (disable_wr) pend_d = 1'b0;
  end

  always_comb begin
    en_d    = en_q;
    k_d     = k_q;
    decim_d = decim_q;
    ovr_d   = ovr_q;
    if (wr_ctrl) begin
      en_d = cfg_data_in[0];
      k_d  = cfg_data_in[3:1];
    end
    if (wr_decim) decim_d = cfg_data_in[7:0];
    if (ovr_inc && (ovr_q != 8'hFF)) ovr_d = ovr_q + 8'd1;
    if (wr_ovr) ovr_d = 8'd0;
  end

  always_comb begin
    cfg_data_out = '0;
    if (in_range) begin
      case (reg_sel)
        2'd0:    cfg_data_out[3:0] = {k_q, en_q};
        2'd1:    cfg_data_out[7:0] = decim_q;
        2'd2:    cfg_data_out[7:0] = ovr_q;
        default: cfg_data_out      = acc_q[ACC_W-1:FRAC];
      endcase
    end
  end

  assign ema_overrun = (ovr_q != 8'd0);

  logic unused_bits;
  assign unused_bits = ^{cfg_data_in[DATA_W-1:8], step[ACC_W], off[ADDR_W:2]};

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q        <= 1'b0;
      k_q         <= 3'd3;
      decim_q     <= 8'd0;
      ovr_q       <= 8'd0;
      cnt_q       <= 8'd0;
      seeded_q    <= 1'b0;
      acc_q       <= '0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      data_q      <= '0;
    end else begin
      en_q        <= en_d;
      k_q         <= k_d;
      decim_q     <= decim_d;
      ovr_q       <= ovr_d;
      cnt_q       <= cnt_d;
      seeded_q    <= seeded_d;
      acc_q       <= acc_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      data_q      <= data_d;
    end
  end

endmodule

// File: tb/tb_ema_sender.sv
// Bench for ema_sender: comparator responder, start monitor, EMA reference model.
module tb_ema_sender;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        start;
  logic [15:0] data;
  logic        finish;
  logic        overrun;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [15:0] cfg_data_in;
  logic [15:0] cfg_data_out;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  ema_sender dut (
    .clk                     (clk),
    .rst                     (rst),
    .in_valid                (in_valid),
    .in_data                 (in_data),
    .ematop_thcomptop_start  (start),
    .ematop_thcomptop_data   (data),
    .thcomptop_ematop_finish (finish),
    .ema_overrun             (overrun),
    .cfg_we                  (cfg_we),
    .cfg_addr                (cfg_addr),
    .cfg_data_in             (cfg_data_in),
    .cfg_data_out            (cfg_data_out),
    .dbg_state_o             (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Reference model state
  longint m_acc;
  bit     m_seeded;
  bit     m_en;
  int     m_k;
  int     m_decim;
  int     m_cnt;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];

  // Comparator responder
  bit fin_auto  = 1'b0;
  int fin_delay = 3;
  int fin_cnt   = 0;
  bit fin_req   = 1'b0;

  initial begin
    finish = 1'b0;
    forever begin
      @(negedge clk);
      finish = 1'b0;
      if (fin_req) begin
        finish  = 1'b1;
        fin_req = 1'b0;
      end
      if (fin_cnt > 0) begin
        fin_cnt--;
        if (fin_cnt == 0) finish = 1'b1;
      end
      if (start && fin_auto && !rst) fin_cnt = fin_delay;
      if (rst) fin_cnt = 0;
    end
  end

  // Start monitor
  bit prev_start = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && start) begin
        got_q.push_back(data);
        total++;
        if (prev_start) begin
          bad++;
          $display("FAIL start_consecutive: start=1 two cycles in a row, required gap");
        end
      end
      prev_start = start && !rst;
    end
  end

  function automatic logic [15:0] model_ema();
    longint e;
    e = m_acc >>> 8;
    return e[15:0];
  endfunction

  task automatic model_reset();
    m_acc = 0; m_seeded = 0; m_en = 0; m_k = 3; m_decim = 0; m_cnt = 0;
  endtask

  // Driver tasks
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [15:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data_in = d;
    tick(1);
    cfg_we = 1'b0;
    if (a == 4'h4) begin
      m_en = d[0];
      m_k  = int'(d[3:1]);
      if (!d[0]) begin
        m_seeded = 0;
        m_cnt    = 0;
      end
    end else if (a == 4'h5) begin
      m_decim = int'(d[7:0]);
      m_cnt   = 0;
    end
  endtask

  task automatic cfg_read(input logic [3:0] a, output logic [15:0] d);
    cfg_addr = a;
    #1;
    d = cfg_data_out;
  endtask

  task automatic send_sample(input logic [15:0] s);
    longint sl;
    in_valid = 1'b1; in_data = s;
    tick(1);
    in_valid = 1'b0;
    if (m_en) begin
      sl = longint'($signed(s)) * 256;
      if (!m_seeded) m_acc = sl;
      else           m_acc = m_acc + ((sl - m_acc) >>> m_k);
      m_seeded = 1;
      if (m_cnt == m_decim) begin
        m_cnt = 0;
        exp_q.push_back(model_ema());
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic manual_finish();
    fin_req = 1'b1;
    tick(1);
  endtask

  task automatic clear_sb();
    exp_q.delete();
    got_q.delete();
  endtask

  // Tests
  task automatic test_reset();
    logic [15:0] r;
    total++; if (start !== 1'b0) begin bad++; $display("FAIL rst_start: got %0b want 0", start); end
    total++; if (data !== 16'h0) begin bad++; $display("FAIL rst_data: got %h want 0000", data); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rst_overrun: got %0b want 0", overrun); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
    cfg_read(4'h4, r);
    total++; if (r !== 16'h0006) begin bad++; $display("FAIL rst_ctrl: got %h want 0006", r); end
    cfg_read(4'h5, r);
    total++; if (r !== 16'h0000) begin bad++; $display("FAIL rst_decim: got %h want 0000", r); end
    cfg_read(4'h6, r);
    total++; if (r !== 16'h0000) begin bad++; $display("FAIL rst_ovr: got %h want 0000", r); end
    cfg_read(4'h7, r);
    total++; if (r !== 16'h0000) begin bad++; $display("FAIL rst_ema: got %h want 0000", r); end
    cfg_read(4'h3, r);
    total++; if (r !== 16'h0000) begin bad++; $display("FAIL rst_outside_lo: got %h want 0000", r); end
    cfg_read(4'h8, r);
    total++; if (r !== 16'h0000) begin bad++; $display("FAIL rst_outside_hi: got %h want 0000", r); end
  endtask

  task automatic test_k0();
    clear_sb();
    fin_auto = 1'b1; fin_delay = 3;
    cfg_write(4'h4, 16'h0001);
    send_sample(16'd100);
    total++; if (start !== 1'b1 || data !== 16'd100) begin
      bad++; $display("FAIL k0_first_latency: start=%0b data=%h want 1/0064", start, data);
    end
    tick(8);
    send_sample(-16'sd50);
    tick(8);
    total++; if (got_q.size() != 2) begin bad++; $display("FAIL k0_count: got %0d want 2", got_q.size()); end
    else begin
      total++; if (got_q[0] !== 16'd100) begin bad++; $display("FAIL k0_data0: got %h want 0064", got_q[0]); end
      total++; if (got_q[1] !== 16'hFFCE) begin bad++; $display("FAIL k0_data1: got %h want ffce", got_q[1]); end
    end
  endtask

  task automatic test_k2();
    logic [15:0] r;
    logic [15:0] want [3];
    logic [15:0] smp [3];
    want[0] = 16'd400; want[1] = 16'd300; want[2] = 16'd225;
    smp[0] = 16'd400; smp[1] = 16'd0; smp[2] = 16'd0;
    clear_sb();
    cfg_write(4'h4, 16'h0000);
    cfg_write(4'h4, 16'h0005);
    for (int i = 0; i < 3; i++) begin
      send_sample(smp[i]);
      cfg_read(4'h7, r);
      total++; if (r !== want[i] || r !== model_ema()) begin
        bad++; $display("FAIL k2_readback%0d: got %h want %h", i, r, want[i]);
      end
      tick(8);
    end
    total++; if (got_q.size() != 3) begin bad++; $display("FAIL k2_count: got %0d want 3", got_q.size()); end
    else for (int i = 0; i < 3; i++) begin
      total++; if (got_q[i] !== want[i]) begin bad++; $display("FAIL k2_data%0d: got %h want %h", i, got_q[i], want[i]); end
    end
  endtask

  task automatic test_k1_floor();
    logic [15:0] r;
    clear_sb();
    cfg_write(4'h4, 16'h0000);
    cfg_write(4'h4, 16'h0003);
    send_sample(16'd0);
    tick(8);
    send_sample(16'hFFFF);
    cfg_read(4'h7, r);
    total++; if (r !== 16'hFFFF) begin bad++; $display("FAIL k1_readback: got %h want ffff", r); end
    total++; if (m_acc != -128) begin bad++; $display("FAIL k1_model_acc: got %0d want -128", m_acc); end
    tick(8);
    total++; if (got_q.size() != 2) begin bad++; $display("FAIL k1_count: got %0d want 2", got_q.size()); end
    else begin
      total++; if (got_q[0] !== 16'h0000) begin bad++; $display("FAIL k1_data0: got %h want 0000", got_q[0]); end
      total++; if (got_q[1] !== 16'hFFFF) begin bad++; $display("FAIL k1_data1: got %h want ffff", got_q[1]); end
    end
  endtask

  task automatic test_decim();
    logic exp_start;
    clear_sb();
    cfg_write(4'h4, 16'h0000);
    cfg_write(4'h4, 16'(($urandom_range(0, 7) << 1) | 1));
    cfg_write(4'h5, 16'd3);
    for (int i = 0; i < 8; i++) begin
      send_sample(16'($urandom));
      exp_start = (i == 3) || (i == 7);
      total++; if (start !== exp_start) begin
        bad++; $display("FAIL decim_start_after%0d: got %0b want %0b", i + 1, start, exp_start);
      end
    end
    tick(10);
    total++; if (got_q.size() != 2 || exp_q.size() != 2) begin
      bad++; $display("FAIL decim_count: got %0d want 2", got_q.size());
    end else for (int i = 0; i < 2; i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL decim_data%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_overrun();
    logic [15:0] r;
    clear_sb();
    fin_auto = 1'b0;
    cfg_write(4'h4, 16'h0000);
    cfg_write(4'h4, 16'h0001);
    cfg_write(4'h5, 16'd0);
    send_sample(16'd5);
    tick(3);
    send_sample(16'd10);
    tick(2);
    send_sample(16'd20);
    tick(2);
    send_sample(16'd30);
    tick(1);
    cfg_read(4'h6, r);
    total++; if (r !== 16'd2) begin bad++; $display("FAIL ovr_count: got %0d want 2", r); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag: got %0b want 1", overrun); end
    total++; if (start !== 1'b0) begin bad++; $display("FAIL ovr_no_start_while_busy: got %0b want 0", start); end
    manual_finish();
    total++; if (start !== 1'b1 || data !== 16'd30) begin
      bad++; $display("FAIL ovr_resend: start=%0b data=%h want 1/001e", start, data);
    end
    tick(2);
    manual_finish();
    total++; if (start !== 1'b0 || dbg_state !== 2'd0) begin
      bad++; $display("FAIL ovr_back_idle: start=%0b state=%0d want 0/0", start, dbg_state);
    end
    cfg_write(4'h6, 16'h1234);
    cfg_read(4'h6, r);
    total++; if (r !== 16'd0) begin bad++; $display("FAIL ovr_clear: got %0d want 0", r); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_flag_clear: got %0b want 0", overrun); end
    total++; if (got_q.size() != 2) begin bad++; $display("FAIL ovr_sends: got %0d want 2", got_q.size()); end
    else begin
      total++; if (got_q[0] !== 16'd5) begin bad++; $display("FAIL ovr_data0: got %h want 0005", got_q[0]); end
    end
  endtask

  task automatic test_random();
    logic [15:0] r;
    clear_sb();
    fin_auto  = 1'b1;
    fin_delay = $urandom_range(1, 4);
    cfg_write(4'h4, 16'h0000);
    cfg_write(4'h4, 16'(($urandom_range(0, 7) << 1) | 1));
    cfg_write(4'h5, 16'($urandom_range(0, 3)));
    for (int i = 0; i < 30; i++) begin
      if (i == 15) begin
        cfg_write(4'h4, 16'h0000);
        for (int j = 0; j < 3; j++) send_sample(16'($urandom));
        tick(2);
        cfg_write(4'h4, 16'(($urandom_range(0, 7) << 1) | 1));
      end
      send_sample(16'($urandom));
      cfg_read(4'h7, r);
      total++; if (r !== model_ema()) begin bad++; $display("FAIL rand_ema%0d: got %h want %h", i, r, model_ema()); end
      tick($urandom_range(8, 12));
    end
    total++; if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size());
    end else for (int i = 0; i < exp_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_data%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] r;
    fin_auto = 1'b0;
    cfg_write(4'h4, 16'h0001);
    cfg_write(4'h5, 16'd0);
    send_sample(16'd77);
    tick(2);
    total++; if (dbg_state !== 2'd2) begin bad++; $display("FAIL rmid_in_wait: got %0d want 2", dbg_state); end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    model_reset();
    clear_sb();
    total++; if (start !== 1'b0 || dbg_state !== 2'd0) begin
      bad++; $display("FAIL rmid_idle: start=%0b state=%0d want 0/0", start, dbg_state);
    end
    cfg_read(4'h4, r);
    total++; if (r !== 16'h0006) begin bad++; $display("FAIL rmid_ctrl: got %h want 0006", r); end
    cfg_read(4'h6, r);
    total++; if (r !== 16'h0000) begin bad++; $display("FAIL rmid_ovr: got %h want 0000", r); end
    manual_finish();
    tick(4);
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL rmid_no_start: got %0d starts want 0", got_q.size()); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data_in = '0;
    model_reset();
    tick(3);
    rst = 1'b0;
    tick(1);
    test_reset();
    test_k0();
    test_k2();
    test_k1_floor();
    test_decim();
    test_overrun();
    test_random();
    test_reset_mid();
    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
